// File: rtl/alu_result_stage.sv
// Registered ALU output stage: selects one unit result by opcode, derives status flags,
// buffers {op, y, flags} in a 2-entry FIFO and tracks sticky ovf/err plus a saturating error count.
module alu_result_stage #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_op,
  input  logic [WIDTH-1:0]     i_y_sub,
  input  logic [WIDTH-1:0]     i_y_nand,
  input  logic [WIDTH-1:0]     i_y_ones,
  input  logic [WIDTH-1:0]     i_y_oh,
  input  logic [3:0]           i_ovf,
  input  logic [3:0]           i_err,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_y,
  output logic [1:0]           o_op,
  output logic [3:0]           o_flags,
  input  logic                 i_clr,
  output logic                 o_sticky_ovf,
  output logic                 o_sticky_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // o_ready and o_valid depend only on registered state, never on i_valid or i_ready.

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [1:0]       op_mem   [2];
  logic [WIDTH-1:0] y_mem    [2];
  logic [3:0]       flag_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             rst_q;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] sel_y;
  logic             sel_ovf;
  logic             sel_err;
  logic             sel_zero;
  logic             sel_neg;

  always_comb begin
    sel_y   = i_y_sub;
    sel_neg = 1'b0;
    case (i_op)
      2'b00: begin sel_y = i_y_sub;  sel_neg = i_y_sub[WIDTH-1];  end
      2'b01: begin sel_y = i_y_nand; sel_neg = i_y_nand[WIDTH-1]; end
      // Leading-ones count and one-hot code are unsigned, so never negative.
      2'b10: begin sel_y = i_y_ones; sel_neg = 1'b0; end
      default: begin sel_y = i_y_oh; sel_neg = 1'b0; end
    endcase
    sel_ovf  = i_ovf[i_op];
    sel_err  = i_err[i_op];
    sel_zero = (sel_y == '0);
  end

  // rst_q keeps o_ready low for the reset cycles and the first cycle after release.
  assign o_ready = (count != 2'd2) && !rst_q;
  assign o_valid = (count != 2'd0);
  assign accept  = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  assign o_y     = y_mem[rd_ptr];
  assign o_op    = op_mem[rd_ptr];
  assign o_flags = flag_mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_q  <= 1'b1;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        op_mem[i]   <= 2'b00;
        y_mem[i]    <= '0;
        flag_mem[i] <= 4'b0000;
      end
    end else begin
      rst_q <= 1'b0;
      if (accept) begin
        op_mem[wr_ptr]   <= i_op;
        y_mem[wr_ptr]    <= sel_y;
        flag_mem[wr_ptr] <= {sel_err, sel_ovf, sel_zero, sel_neg};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with an accept leaves only the new entry's contribution.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sticky_ovf <= 1'b0;
      o_sticky_err <= 1'b0;
      o_err_cnt    <= '0;
    end else if (i_clr) begin
      o_sticky_ovf <= accept && sel_ovf;
      o_sticky_err <= accept && sel_err;
      o_err_cnt    <= (accept && sel_err) ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (accept) begin
      o_sticky_ovf <= o_sticky_ovf | sel_ovf;
      o_sticky_err <= o_sticky_err | sel_err;
      if (sel_err && (o_err_cnt != CNT_MAX)) begin
        o_err_cnt <= o_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: randomized and directed traffic, scoreboard queue of expected
// entries filled on accept, drained by a negedge monitor on every output transfer.
module tb_alu_result_stage;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int EW = W + 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [1:0]    i_op = 2'b00;
  logic [W-1:0]  i_y_sub = '0, i_y_nand = '0, i_y_ones = '0, i_y_oh = '0;
  logic [3:0]    i_ovf = 4'h0, i_err = 4'h0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_y;
  logic [1:0]    o_op;
  logic [3:0]    o_flags;
  logic          i_clr = 1'b0;
  logic          o_sticky_ovf, o_sticky_err;
  logic [CW-1:0] o_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [EW-1:0] exp_q[$];
  logic ready_m = 1'b0;
  logic rst_m = 1'b0;
  logic started = 1'b0;
  logic m_sovf = 1'b0, m_serr = 1'b0;
  int   m_cnt = 0;

  alu_result_stage #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_y_sub(i_y_sub), .i_y_nand(i_y_nand), .i_y_ones(i_y_ones), .i_y_oh(i_y_oh),
    .i_ovf(i_ovf), .i_err(i_err), .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y),
    .o_op(o_op), .o_flags(o_flags), .i_clr(i_clr), .o_sticky_ovf(o_sticky_ovf),
    .o_sticky_err(o_sticky_err), .o_err_cnt(o_err_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference: pick the unit by opcode, flags straight from their definitions.
  function automatic logic [EW-1:0] model_entry(input logic [1:0] op,
      input logic [W-1:0] ys, input logic [W-1:0] yn, input logic [W-1:0] yo,
      input logic [W-1:0] yh, input logic [3:0] ovf, input logic [3:0] err);
    logic [W-1:0] y;
    logic neg;
    y   = (op == 2'd0) ? ys : (op == 2'd1) ? yn : (op == 2'd2) ? yo : yh;
    neg = (op < 2'd2) && (int'(y) >= (1 << (W - 1)));
    return {op, y, err[op], ovf[op], (y == '0), neg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard push: evaluated at the accepting edge from the model's own readiness.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    if (i_rst) begin
      exp_q.delete();
      rst_m   = 1'b1;
      started = 1'b1;
      m_sovf  = 1'b0;
      m_serr  = 1'b0;
      m_cnt   = 0;
    end else begin
      rst_m = 1'b0;
      if (i_clr) begin
        m_sovf = 1'b0;
        m_serr = 1'b0;
        m_cnt  = 0;
      end
      if (i_valid && ready_m) begin
        e = model_entry(i_op, i_y_sub, i_y_nand, i_y_ones, i_y_oh, i_ovf, i_err);
        exp_q.push_back(e);
        m_sovf = m_sovf | e[2];
        m_serr = m_serr | e[3];
        if (e[3] && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  end

  // Monitor: checks handshake/status each cycle and pops on every output transfer.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic exp_ready;
    if (started) begin
      exp_ready = (exp_q.size() < 2) && !rst_m;
      check("o_ready", 32'(o_ready), 32'(exp_ready));
      check("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
      check("o_sticky_ovf", 32'(o_sticky_ovf), 32'(m_sovf));
      check("o_sticky_err", 32'(o_sticky_err), 32'(m_serr));
      check("o_err_cnt", 32'(o_err_cnt), 32'(m_cnt));
      if (rst_m) begin
        check("rst_o_y", 32'(o_y), 32'd0);
        check("rst_o_op", 32'(o_op), 32'd0);
        check("rst_o_flags", 32'(o_flags), 32'd0);
      end
      if (exp_q.size() != 0 && i_ready) begin
        e = exp_q.pop_front();
        check("o_y", 32'(o_y), 32'(e[W+3:4]));
        check("o_op", 32'(o_op), 32'(e[EW-1:W+4]));
        check("o_flags", 32'(o_flags), 32'(e[3:0]));
      end
      ready_m = exp_ready;
    end
  end

  // driver tasks
  task automatic load(input logic [1:0] op, input logic [W-1:0] ys, input logic [W-1:0] yn,
      input logic [W-1:0] yo, input logic [W-1:0] yh, input logic [3:0] ovf, input logic [3:0] err);
    i_op = op; i_y_sub = ys; i_y_nand = yn; i_y_ones = yo; i_y_oh = yh; i_ovf = ovf; i_err = err;
  endtask

  task automatic load_rand();
    load(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
         4'($urandom), 4'($urandom));
  endtask

  task automatic send();
    logic rdy;
    logic ok;
    ok = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    idle(2);

    // Subtractor entry: negative with overflow.
    i_ready = 1'b1;
    load(2'b00, 4'b1101, W'($urandom), W'($urandom), W'($urandom), 4'b0001, 4'b0000);
    send();
    i_valid = 1'b0;
    @(negedge clk);
    check("tp_sub_y", 32'(o_y), 32'hD);
    check("tp_sub_flags", 32'(o_flags), 32'h5);
    @(posedge clk); #1;

    // Unsigned count with MSB set, then zero one-hot with error.
    load(2'b10, W'($urandom), W'($urandom), 4'b1000, W'($urandom), 4'b0000, 4'b0000);
    send();
    load(2'b11, W'($urandom), W'($urandom), W'($urandom), 4'b0000, 4'b0000, 4'b1000);
    send();
    i_valid = 1'b0;
    @(negedge clk);
    check("tp_oh_flags", 32'(o_flags), 32'hA);
    check("tp_oh_errcnt", 32'(o_err_cnt), 32'd1);
    @(posedge clk); #1;
    idle(2);

    // Backpressure: A and B fill the buffer, C waits until i_ready rises.
    i_ready = 1'b0;
    load_rand(); send();
    load_rand(); send();
    fork
      begin repeat (4) @(posedge clk); #2 i_ready = 1'b1; end
    join_none
    load_rand(); send();
    idle(4);

    // Streaming at count 1 with simultaneous accept and pop.
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin load_rand(); send(); end
    idle(3);

    // Error counter saturation, then clear coinciding with an erroring accept.
    for (int i = 0; i < 5; i++) begin
      load(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
           4'($urandom), 4'hF);
      send();
    end
    idle(1);
    @(negedge clk);
    check("sat_errcnt", 32'(o_err_cnt), 32'(CNT_MAX));
    @(posedge clk); #1;
    load(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
         4'h0, 4'hF);
    i_clr = 1'b1;
    send();
    i_clr = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("clr_errcnt", 32'(o_err_cnt), 32'd1);
    check("clr_sticky_err", 32'(o_sticky_err), 32'd1);
    @(posedge clk); #1;
    i_clr = 1'b1;
    idle(1);
    i_clr = 1'b0;
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      load_rand();
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      i_clr   = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    i_clr = 1'b0;
    i_ready = 1'b1;
    idle(4);

    // Reset while full, then a fresh entry with one-cycle latency.
    i_ready = 1'b0;
    load_rand(); send();
    load_rand(); send();
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    idle(1);
    i_ready = 1'b1;
    load(2'b01, W'($urandom), 4'b0000, W'($urandom), W'($urandom), 4'h0, 4'h0);
    send();
    i_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_flags", 32'(o_flags), 32'h2);
    @(posedge clk); #1;

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
